// File: rtl/swalloc_pipe_pkg.sv
// Shared helpers for the switch allocator: sizing, popcount, circular
// first-k selection and the per-channel ppv packing rule.
package swalloc_pipe_pkg;

    localparam int MAX_PORT = 32;

    typedef logic [MAX_PORT-1:0] pvec_t;

    function automatic int clog2_min1(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int popcnt(input pvec_t v);
        int c;
        c = 0;
        for (int b = 0; b < MAX_PORT; b++) c += int'(v[b]);
        return c;
    endfunction

    // Channel ch owns ppv/alloc bits [ch*n_port +: n_port].
    function automatic int ppv_lsb(input int ch, input int n_port);
        return ch * n_port;
    endfunction

    // Keep the first k set bits of v[n-1:0], scanning upward from start and wrapping.
    function automatic pvec_t circ_first_k(input pvec_t v, input int n, input int start, input int k);
        pvec_t g;
        int    got;
        int    idx;
        g   = '0;
        got = 0;
        for (int s = 0; s < MAX_PORT; s++) begin
            if (s < n) begin
                idx = start + s;
                if (idx >= n) idx = idx - n;
                if (v[idx[4:0]] && got < k) begin
                    g[idx[4:0]] = 1'b1;
                    got++;
                end
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/swalloc_pipe_stage.sv
// One rank position of the allocation chain: grants ports to a single channel
// from the mask left over by higher-ranked channels.
module swalloc_stage
    import swalloc_pipe_pkg::*;
#(
    parameter int N_PORT  = 4,
    parameter int RR_W    = 2,
    parameter int LATER_W = 3
) (
    input  logic [N_PORT-1:0]  i_ppv,
    input  logic               i_mc,
    input  logic               i_valid,
    input  logic [N_PORT-1:0]  i_avail,
    input  logic [LATER_W-1:0] i_later,
    input  logic [RR_W-1:0]    i_rr,
    output logic [N_PORT-1:0]  o_alloc,
    output logic               o_defl,
    output logic               o_ovf,
    output logic [N_PORT-1:0]  o_avail
);

    logic [N_PORT-1:0] w_p;
    pvec_t             w_pv;
    pvec_t             w_av;
    pvec_t             w_ppv;
    int                w_n_p;
    int                w_n_a;
    int                w_n_ppv;
    int                w_budget;
    int                w_k;

    assign w_p = i_ppv & i_avail;

    always_comb begin
        w_pv  = '0;
        w_av  = '0;
        w_ppv = '0;
        w_pv[N_PORT-1:0]  = w_p;
        w_av[N_PORT-1:0]  = i_avail;
        w_ppv[N_PORT-1:0] = i_ppv;
        w_n_p    = popcnt(w_pv);
        w_n_a    = popcnt(w_av);
        w_n_ppv  = popcnt(w_ppv);
        // Leave at least one port for each lower-ranked valid channel, but always grant one.
        w_budget = w_n_a - int'(i_later);
        if (w_budget < 1) w_budget = 1;
        w_k      = (w_budget < w_n_p) ? w_budget : w_n_p;

        o_alloc = '0;
        o_defl  = 1'b0;
        o_ovf   = 1'b0;
        if (i_valid) begin
            if (i_avail == '0) begin
                o_ovf = 1'b1;
            end else if (w_p == '0) begin
                o_alloc = N_PORT'(circ_first_k(w_av, N_PORT, int'(i_rr), 1));
                o_defl  = 1'b1;
            end else if (i_mc && w_n_ppv >= 2) begin
                o_alloc = N_PORT'(circ_first_k(w_pv, N_PORT, int'(i_rr), w_k));
            end else begin
                o_alloc = N_PORT'(circ_first_k(w_pv, N_PORT, int'(i_rr), 1));
            end
        end
    end

    assign o_avail = i_avail & ~o_alloc;

endmodule

// File: rtl/swalloc_pipe.sv
// Pipelined rank-ordered switch allocator: optional input register, a chain of
// per-channel stages, registered outputs, rotating pointer and deflection counter.
module swalloc_pipe
    import swalloc_pipe_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int N_PORT  = 4,
    parameter int LATENCY = 1,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_vld,
    input  logic [N_CH-1:0]          ch_valid,
    input  logic [N_CH-1:0]          ch_mc,
    input  logic [N_CH*N_PORT-1:0]   ch_ppv,
    input  logic [N_PORT-1:0]        port_en,
    output logic                     out_vld,
    output logic [N_CH*N_PORT-1:0]   alloc_pv,
    output logic [N_CH-1:0]          defl_mask,
    output logic                     err_overflow,
    output logic [CNT_W-1:0]         defl_cnt
);

    localparam int RR_W    = clog2_min1(N_PORT);
    localparam int LATER_W = clog2_min1(N_CH + 1);
    localparam int SUM_W   = CNT_W + LATER_W;

    logic                   w_vld;
    logic [N_CH-1:0]        w_valid;
    logic [N_CH-1:0]        w_mc;
    logic [N_CH*N_PORT-1:0] w_ppv;
    logic [N_PORT-1:0]      w_en;

    generate
        if (LATENCY == 2) begin : g_in_reg
            logic                   r_vld;
            logic [N_CH-1:0]        r_valid;
            logic [N_CH-1:0]        r_mc;
            logic [N_CH*N_PORT-1:0] r_ppv;
            logic [N_PORT-1:0]      r_en;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_vld   <= 1'b0;
                    r_valid <= '0;
                    r_mc    <= '0;
                    r_ppv   <= '0;
                    r_en    <= '0;
                end else begin
                    r_vld   <= in_vld;
                    r_valid <= ch_valid;
                    r_mc    <= ch_mc;
                    r_ppv   <= ch_ppv;
                    r_en    <= port_en;
                end
            end

            assign w_vld   = r_vld;
            assign w_valid = r_valid;
            assign w_mc    = r_mc;
            assign w_ppv   = r_ppv;
            assign w_en    = r_en;
        end else begin : g_in_comb
            assign w_vld   = in_vld;
            assign w_valid = ch_valid;
            assign w_mc    = ch_mc;
            assign w_ppv   = ch_ppv;
            assign w_en    = port_en;
        end
    endgenerate

    // Channels only count as present while the bundle itself is valid.
    logic [N_CH-1:0]              w_chv;
    logic [N_CH-1:0][LATER_W-1:0] w_later;

    assign w_chv = w_valid & {N_CH{w_vld}};

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            w_later[i] = '0;
            for (int j = i + 1; j < N_CH; j++) w_later[i] = w_later[i] + LATER_W'(w_chv[j]);
        end
    end

    logic [RR_W-1:0]           r_rr;
    logic [N_CH:0][N_PORT-1:0] w_avail;
    logic [N_CH*N_PORT-1:0]    w_alloc;
    logic [N_CH-1:0]           w_defl;
    logic [N_CH-1:0]           w_ovf;
    logic [N_PORT-1:0]         w_unused_avail;

    assign w_avail[0]     = w_en;
    assign w_unused_avail = w_avail[N_CH];

    for (genvar i = 0; i < N_CH; i++) begin : g_stage
        swalloc_stage #(
            .N_PORT  (N_PORT),
            .RR_W    (RR_W),
            .LATER_W (LATER_W)
        ) u_stage (
            .i_ppv   (w_ppv[ppv_lsb(i, N_PORT) +: N_PORT]),
            .i_mc    (w_mc[i]),
            .i_valid (w_chv[i]),
            .i_avail (w_avail[i]),
            .i_later (w_later[i]),
            .i_rr    (r_rr),
            .o_alloc (w_alloc[ppv_lsb(i, N_PORT) +: N_PORT]),
            .o_defl  (w_defl[i]),
            .o_ovf   (w_ovf[i]),
            .o_avail (w_avail[i+1])
        );
    end

    logic [LATER_W-1:0] w_ndefl;
    logic [SUM_W-1:0]   w_sum;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [RR_W-1:0]    w_rr_next;
    logic               r_out_vld;
    logic [N_CH*N_PORT-1:0] r_alloc;
    logic [N_CH-1:0]    r_defl;
    logic               r_ovf;
    logic [CNT_W-1:0]   r_cnt;

    always_comb begin
        w_ndefl = '0;
        for (int i = 0; i < N_CH; i++) w_ndefl = w_ndefl + LATER_W'(w_defl[i]);
        w_sum = SUM_W'(r_cnt) + SUM_W'(w_ndefl);
        if (|w_sum[SUM_W-1:CNT_W]) w_cnt_next = '1;
        else                       w_cnt_next = w_sum[CNT_W-1:0];
        // Pointer steps only after a bundle that deflected something.
        w_rr_next = r_rr;
        if (|w_defl) w_rr_next = (r_rr == RR_W'(N_PORT - 1)) ? '0 : r_rr + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_vld <= 1'b0;
            r_alloc   <= '0;
            r_defl    <= '0;
            r_ovf     <= 1'b0;
            r_cnt     <= '0;
            r_rr      <= '0;
        end else begin
            r_out_vld <= w_vld;
            r_alloc   <= w_alloc;
            r_defl    <= w_defl;
            r_ovf     <= |w_ovf;
            r_cnt     <= w_cnt_next;
            r_rr      <= w_rr_next;
        end
    end

    assign out_vld      = r_out_vld;
    assign alloc_pv     = r_alloc;
    assign defl_mask    = r_defl;
    assign err_overflow = r_ovf;
    assign defl_cnt     = r_cnt;

endmodule
